multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller_if.sv | 42 ++++
 rtl/multicycle_controller.sv | 188 ++++++++++++++++++
 tb/tb_multicycle_controller.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_controller_if
// Description : Instruction-field inputs and datapath control outputs of the
//               multicycle controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_controller_if;
  logic [5:0] opcode;
  logic [5:0] func;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic [1:0] reg_dst;
  logic [1:0] mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic [1:0] pc_src;
  logic       illegal_op;

  // The controller commands the datapath, so it is the master side.
  modport master (
    input  opcode, func, zero, mem_ready,
    output pc_write, iord, mem_read, mem_write, ir_write, reg_write,
           reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src,
           illegal_op
  );

  modport slave (
    output opcode, func, zero, mem_ready,
    input  pc_write, iord, mem_read, mem_write, ir_write, reg_write,
           reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src,
           illegal_op
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_controller
// Description : Multicycle MIPS-subset control FSM driving the datapath selects.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_controller (
  input wire logic               clk,
  input wire logic               rst,
  multicycle_controller_if.master bus
);
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_RTEXEC = 4'd6,  S_RTWB   = 4'd7,
    S_ITEXEC = 4'd8,  S_ITWB   = 4'd9,  S_BRANCH = 4'd10, S_JUMP   = 4'd11,
    S_JAL    = 4'd12, S_JR     = 4'd13
  } state_t;

  localparam logic [5:0] C_OP_RTYPE = 6'b000000;
  localparam logic [5:0] C_OP_LW    = 6'b100011;
  localparam logic [5:0] C_OP_SW    = 6'b101011;
  localparam logic [5:0] C_OP_BEQ   = 6'b000100;
  localparam logic [5:0] C_OP_J     = 6'b000010;
  localparam logic [5:0] C_OP_JAL   = 6'b000011;
  localparam logic [5:0] C_OP_ADDI  = 6'b001000;
  localparam logic [5:0] C_OP_SLTI  = 6'b001010;

  localparam logic [5:0] C_FN_ADD = 6'b100000;
  localparam logic [5:0] C_FN_SUB = 6'b100010;
  localparam logic [5:0] C_FN_AND = 6'b100100;
  localparam logic [5:0] C_FN_OR  = 6'b100101;
  localparam logic [5:0] C_FN_SLT = 6'b101010;
  localparam logic [5:0] C_FN_JR  = 6'b001000;

  localparam logic [2:0] C_ALU_ADD = 3'b000;
  localparam logic [2:0] C_ALU_SUB = 3'b001;
  localparam logic [2:0] C_ALU_AND = 3'b010;
  localparam logic [2:0] C_ALU_OR  = 3'b011;
  localparam logic [2:0] C_ALU_SLT = 3'b100;

  state_t     state_q, state_d;
  logic       rt_legal;
  logic [2:0] rt_alu_op;
  logic       w_pc_write, w_ir_write, w_reg_write, w_mem_write, w_illegal_op;
  logic       w_iord, w_mem_read, w_alu_src_a;
  logic [1:0] w_reg_dst, w_mem_to_reg, w_alu_src_b, w_pc_src;
  logic [2:0] w_alu_op;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  // R-type function decode (JR is legal but handled separately in DECODE).
  always_comb begin
    rt_legal  = 1'b1;
    rt_alu_op = C_ALU_ADD;
    case (bus.func)
      C_FN_ADD: rt_alu_op = C_ALU_ADD;
      C_FN_SUB: rt_alu_op = C_ALU_SUB;
      C_FN_AND: rt_alu_op = C_ALU_AND;
      C_FN_OR:  rt_alu_op = C_ALU_OR;
      C_FN_SLT: rt_alu_op = C_ALU_SLT;
      default:  rt_legal  = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = S_FETCH;
    w_pc_write   = 1'b0;
    w_iord       = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_reg_write  = 1'b0;
    w_reg_dst    = 2'd0;
    w_mem_to_reg = 2'd0;
    w_alu_src_a  = 1'b0;
    w_alu_src_b  = 2'd0;
    w_alu_op     = C_ALU_ADD;
    w_pc_src     = 2'd0;
    w_illegal_op = 1'b0;
    case (state_q)
      S_FETCH: begin
        w_mem_read  = 1'b1;
        w_alu_src_b = 2'd1;
        if (bus.mem_ready) begin
          w_ir_write = 1'b1;
          w_pc_write = 1'b1;
          state_d    = S_DECODE;
        end else begin
          state_d    = S_FETCH;
        end
      end
      S_DECODE: begin
        w_alu_src_b = 2'd3;
        case (bus.opcode)
          C_OP_RTYPE: begin
            if (bus.func == C_FN_JR) state_d = S_JR;
            else if (rt_legal)       state_d = S_RTEXEC;
            else                     w_illegal_op = 1'b1;
          end
          C_OP_LW, C_OP_SW:     state_d = S_MEMADR;
          C_OP_BEQ:             state_d = S_BRANCH;
          C_OP_J:               state_d = S_JUMP;
          C_OP_JAL:             state_d = S_JAL;
          C_OP_ADDI, C_OP_SLTI: state_d = S_ITEXEC;
          default:              w_illegal_op = 1'b1;
        endcase
      end
      S_MEMADR: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'd2;
        if (bus.opcode == C_OP_SW)      state_d = S_MEMWR;
        else if (bus.opcode == C_OP_LW) state_d = S_MEMRD;
      end
      S_MEMRD: begin
        w_mem_read = 1'b1;
        w_iord     = 1'b1;
        state_d    = bus.mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = 2'd1;
      end
      S_MEMWR: begin
        w_mem_write = 1'b1;
        w_iord      = 1'b1;
        state_d     = bus.mem_ready ? S_FETCH : S_MEMWR;
      end
      S_RTEXEC: begin
        w_alu_src_a = 1'b1;
        w_alu_op    = rt_alu_op;
        state_d     = S_RTWB;
      end
      S_RTWB: begin
        w_reg_write = 1'b1;
        w_reg_dst   = 2'd1;
      end
      S_ITEXEC: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'd2;
        w_alu_op    = (bus.opcode == C_OP_SLTI) ? C_ALU_SLT : C_ALU_ADD;
        state_d     = S_ITWB;
      end
      S_ITWB:   w_reg_write = 1'b1;
      S_BRANCH: begin
        w_alu_src_a = 1'b1;
        w_alu_op    = C_ALU_SUB;
        w_pc_src    = 2'd1;
        w_pc_write  = bus.zero;
      end
      S_JUMP: begin
        w_pc_src   = 2'd2;
        w_pc_write = 1'b1;
      end
      // PC already holds PC+4 from FETCH, so the link value is simply PC.
      S_JAL: begin
        w_reg_write  = 1'b1;
        w_reg_dst    = 2'd2;
        w_mem_to_reg = 2'd2;
        w_pc_src     = 2'd2;
        w_pc_write   = 1'b1;
      end
      S_JR: begin
        w_pc_src   = 2'd3;
        w_pc_write = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Write enables are squelched while reset is held, independent of the clock.
  assign bus.pc_write   = w_pc_write   & rst;
  assign bus.ir_write   = w_ir_write   & rst;
  assign bus.reg_write  = w_reg_write  & rst;
  assign bus.mem_write  = w_mem_write  & rst;
  assign bus.illegal_op = w_illegal_op & rst;
  assign bus.iord       = w_iord;
  assign bus.mem_read   = w_mem_read;
  assign bus.reg_dst    = w_reg_dst;
  assign bus.mem_to_reg = w_mem_to_reg;
  assign bus.alu_src_a  = w_alu_src_a;
  assign bus.alu_src_b  = w_alu_src_b;
  assign bus.alu_op     = w_alu_op;
  assign bus.pc_src     = w_pc_src;
endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_controller
// Description : Self-checking bench for the multicycle controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_controller;
  logic clk;
  logic rst;

  multicycle_controller_if bus();

  multicycle_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_src;
    logic       illegal_op;
  } ctl_t;

  // One step of an instruction: its control word plus how it reacts to inputs.
  typedef struct {
    ctl_t base;
    bit   waits;
    bit   fetch;
    bit   branch;
  } step_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    int         lat;
    bit         ill;
  } vec_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
  } instr_t;

  int    n_checks = 0;
  int    n_fail   = 0;
  step_t plan[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic ctl_t observe();
    ctl_t c;
    c.pc_write   = bus.pc_write;
    c.iord       = bus.iord;
    c.mem_read   = bus.mem_read;
    c.mem_write  = bus.mem_write;
    c.ir_write   = bus.ir_write;
    c.reg_write  = bus.reg_write;
    c.reg_dst    = bus.reg_dst;
    c.mem_to_reg = bus.mem_to_reg;
    c.alu_src_a  = bus.alu_src_a;
    c.alu_src_b  = bus.alu_src_b;
    c.alu_op     = bus.alu_op;
    c.pc_src     = bus.pc_src;
    c.illegal_op = bus.illegal_op;
    return c;
  endfunction

  function automatic bit is_fetch();
    return bus.mem_read && !bus.iord && bus.alu_src_b == 2'd1;
  endfunction

  function automatic bit is_decode();
    return !bus.mem_read && bus.alu_src_b == 2'd3;
  endfunction

  function automatic ctl_t fetch_ctl();
    ctl_t c = '0;
    c.mem_read  = 1'b1;
    c.alu_src_b = 2'd1;
    return c;
  endfunction

  function automatic logic [2:0] rt_alu(input logic [5:0] fn);
    case (fn)
      6'h22:   return 3'd1;
      6'h24:   return 3'd2;
      6'h25:   return 3'd3;
      6'h2a:   return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  function automatic bit legal(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h00)
      return fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h08};
    return op inside {6'h23, 6'h2b, 6'h04, 6'h02, 6'h03, 6'h08, 6'h0a};
  endfunction

  function automatic void push(input ctl_t c, input bit w, input bit f, input bit b);
    step_t s;
    s.base = c; s.waits = w; s.fetch = f; s.branch = b;
    plan.push_back(s);
  endfunction

  // Reference model: the full step list an instruction walks through.
  function automatic void plan_instr(input logic [5:0] op, input logic [5:0] fn);
    ctl_t c;
    plan.delete();
    push(fetch_ctl(), 1'b1, 1'b1, 1'b0);
    c = '0; c.alu_src_b = 2'd3;
    if (!legal(op, fn)) begin
      c.illegal_op = 1'b1;
      push(c, 1'b0, 1'b0, 1'b0);
      return;
    end
    push(c, 1'b0, 1'b0, 1'b0);
    c = '0;
    case (op)
      6'h23, 6'h2b: begin
        c.alu_src_a = 1'b1; c.alu_src_b = 2'd2;
        push(c, 1'b0, 1'b0, 1'b0);
        c = '0; c.iord = 1'b1;
        if (op == 6'h23) begin
          c.mem_read = 1'b1;
          push(c, 1'b1, 1'b0, 1'b0);
          c = '0; c.reg_write = 1'b1; c.mem_to_reg = 2'd1;
          push(c, 1'b0, 1'b0, 1'b0);
        end else begin
          c.mem_write = 1'b1;
          push(c, 1'b1, 1'b0, 1'b0);
        end
      end
      6'h00: begin
        if (fn == 6'h08) begin
          c.pc_src = 2'd3; c.pc_write = 1'b1;
          push(c, 1'b0, 1'b0, 1'b0);
        end else begin
          c.alu_src_a = 1'b1; c.alu_op = rt_alu(fn);
          push(c, 1'b0, 1'b0, 1'b0);
          c = '0; c.reg_write = 1'b1; c.reg_dst = 2'd1;
          push(c, 1'b0, 1'b0, 1'b0);
        end
      end
      6'h04: begin
        c.alu_src_a = 1'b1; c.alu_op = 3'd1; c.pc_src = 2'd1;
        push(c, 1'b0, 1'b0, 1'b1);
      end
      6'h02: begin
        c.pc_src = 2'd2; c.pc_write = 1'b1;
        push(c, 1'b0, 1'b0, 1'b0);
      end
      6'h03: begin
        c.reg_write = 1'b1; c.reg_dst = 2'd2; c.mem_to_reg = 2'd2;
        c.pc_src = 2'd2; c.pc_write = 1'b1;
        push(c, 1'b0, 1'b0, 1'b0);
      end
      default: begin
        c.alu_src_a = 1'b1; c.alu_src_b = 2'd2;
        c.alu_op = (op == 6'h0a) ? 3'd4 : 3'd0;
        push(c, 1'b0, 1'b0, 1'b0);
        c = '0; c.reg_write = 1'b1;
        push(c, 1'b0, 1'b0, 1'b0);
      end
    endcase
  endfunction

  function automatic ctl_t expect_now(input bit mr, input bit z);
    ctl_t e = plan[0].base;
    if (plan[0].fetch) begin
      e.pc_write = mr;
      e.ir_write = mr;
    end
    if (plan[0].branch) e.pc_write = z;
    return e;
  endfunction

  initial begin
    vec_t       tbl[15];
    instr_t     cands[16];
    int         cnt;
    int         mw;
    bit         ill;
    bit         seen_rw;
    bit         mr;
    bit         z;
    logic [5:0] op_l;
    logic [5:0] fn_l;
    int         idx;

    tbl[0]  = '{6'h23, 6'h00, 5, 1'b0};
    tbl[1]  = '{6'h2b, 6'h00, 4, 1'b0};
    tbl[2]  = '{6'h00, 6'h20, 4, 1'b0};
    tbl[3]  = '{6'h00, 6'h22, 4, 1'b0};
    tbl[4]  = '{6'h00, 6'h24, 4, 1'b0};
    tbl[5]  = '{6'h00, 6'h25, 4, 1'b0};
    tbl[6]  = '{6'h00, 6'h2a, 4, 1'b0};
    tbl[7]  = '{6'h08, 6'h00, 4, 1'b0};
    tbl[8]  = '{6'h0a, 6'h00, 4, 1'b0};
    tbl[9]  = '{6'h04, 6'h00, 3, 1'b0};
    tbl[10] = '{6'h02, 6'h00, 3, 1'b0};
    tbl[11] = '{6'h03, 6'h00, 3, 1'b0};
    tbl[12] = '{6'h00, 6'h08, 3, 1'b0};
    tbl[13] = '{6'h00, 6'h27, 2, 1'b1};
    tbl[14] = '{6'h3f, 6'h20, 2, 1'b1};

    cands[0]  = '{6'h23, 6'h00}; cands[1]  = '{6'h2b, 6'h00};
    cands[2]  = '{6'h00, 6'h20}; cands[3]  = '{6'h00, 6'h22};
    cands[4]  = '{6'h00, 6'h24}; cands[5]  = '{6'h00, 6'h25};
    cands[6]  = '{6'h00, 6'h2a}; cands[7]  = '{6'h00, 6'h08};
    cands[8]  = '{6'h04, 6'h00}; cands[9]  = '{6'h02, 6'h00};
    cands[10] = '{6'h03, 6'h00}; cands[11] = '{6'h08, 6'h00};
    cands[12] = '{6'h0a, 6'h00}; cands[13] = '{6'h00, 6'h27};
    cands[14] = '{6'h3f, 6'h00}; cands[15] = '{6'h0f, 6'h00};

    rst = 1'b0;
    bus.opcode = 6'h00; bus.func = 6'h00; bus.zero = 1'b0; bus.mem_ready = 1'b1;
    #2;
    check("reset_state", observe(), fetch_ctl());

    #10;
    rst = 1'b0 | 1'b1;
    bus.opcode = 6'h02;
    @(posedge clk); #1;
    check("first_edge_decode", is_decode(), 1);
    @(posedge clk); #1;
    check("jump_pc_write", {bus.pc_write, bus.pc_src}, 3'b110);
    @(posedge clk); #1;
    check("jump_back_fetch", is_fetch(), 1);

    foreach (tbl[i]) begin
      bus.opcode = tbl[i].op; bus.func = tbl[i].fn;
      bus.mem_ready = 1'b1; bus.zero = 1'b0;
      #1;
      cnt = 0; ill = 1'b0;
      do begin
        ill |= bus.illegal_op;
        @(posedge clk); #1;
        cnt++;
      end while (!is_fetch() && cnt < 20);
      check($sformatf("latency_%0d", i), cnt, tbl[i].lat);
      check($sformatf("illegal_%0d", i), ill, tbl[i].ill);
    end

    // sw with three memory wait cycles in MEMWR.
    bus.opcode = 6'h2b; mw = 0; seen_rw = 1'b0;
    for (int k = 0; k < 7; k++) begin
      bus.mem_ready = (k >= 3 && k < 6) ? 1'b0 : 1'b1;
      #1;
      mw += bus.mem_write;
      seen_rw |= bus.reg_write;
      @(posedge clk); #1;
    end
    check("sw_mem_write_cycles", mw, 4);
    check("sw_no_reg_write", seen_rw, 0);
    check("sw_back_fetch", is_fetch(), 1);

    // Asynchronous reset while stalled in MEMRD.
    bus.opcode = 6'h23; bus.mem_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    bus.mem_ready = 1'b0; #1;
    check("lw_in_memrd", {bus.mem_read, bus.iord}, 2'b11);
    #1;
    rst = 1'b0; bus.mem_ready = 1'b1;
    #1;
    check("async_reset_outputs", observe(), fetch_ctl());
    @(posedge clk); #1;
    check("held_in_reset", observe(), fetch_ctl());
    #2;
    rst = 1'b1;

    for (int n = 0; n < 400; n++) begin
      idx = $urandom_range(0, 15);
      op_l = cands[idx].op;
      fn_l = (op_l == 6'h00) ? cands[idx].fn : 6'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        op_l = 6'($urandom);
        fn_l = 6'($urandom);
      end
      bus.opcode = op_l; bus.func = fn_l;
      plan_instr(op_l, fn_l);
      while (plan.size() > 0) begin
        mr = ($urandom_range(0, 3) != 0);
        z  = 1'($urandom_range(0, 1));
        bus.mem_ready = mr; bus.zero = z;
        #1;
        check($sformatf("rand_%0d_op%02h_fn%02h", n, op_l, fn_l), observe(), expect_now(mr, z));
        if (!plan[0].waits || mr) void'(plan.pop_front());
        @(posedge clk); #1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
